// File: rtl/energy_pkg.sv
// Shared types and helpers for the Ising energy scheduler.
// Holds the FSM state enum, the row index width and the sign extension used by the accumulator.
package energy_pkg;

    localparam int DATASPIN = 256;
    localparam int IDX_W    = $clog2(DATASPIN);
    localparam int LOCAL_W  = 16;
    localparam int ENERGY_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    function automatic logic signed [ENERGY_W-1:0] sext_energy(
        input logic signed [LOCAL_W-1:0] e
    );
        return ENERGY_W'(e);
    endfunction

endpackage

// File: rtl/energy_calc_scheduler_partial_energy_calc.sv
// Combinational local energy of one row: s_i * (sum_j w_ij*s_j + h_i*hscaling).
// Ports: spin_i, current_spin_i, weight_i, hbias_i, hscaling_i in; energy_o signed out.
module partial_energy_calc #(
    parameter int BITJ             = 4,
    parameter int BITH             = 4,
    parameter int DATASPIN         = 256,
    parameter int SCALING_BIT      = 5,
    parameter int LOCAL_ENERGY_BIT = 16
) (
    input  logic [DATASPIN-1:0]                spin_i,
    input  logic                               current_spin_i,
    input  logic [DATASPIN*BITJ-1:0]           weight_i,
    input  logic [BITH-1:0]                    hbias_i,
    input  logic [SCALING_BIT-1:0]             hscaling_i,
    output logic signed [LOCAL_ENERGY_BIT-1:0] energy_o
);

    logic signed [LOCAL_ENERGY_BIT-1:0] sum;
    logic signed [LOCAL_ENERGY_BIT-1:0] wj;

    // Spin bit 1 is +1 and bit 0 is -1, so each product is +/- weight.
    always_comb begin
        sum = LOCAL_ENERGY_BIT'(signed'(hbias_i))
            * LOCAL_ENERGY_BIT'(signed'(hscaling_i));
        wj  = '0;
        for (int j = 0; j < DATASPIN; j++) begin
            wj  = LOCAL_ENERGY_BIT'(signed'(weight_i[j*BITJ +: BITJ]));
            sum = spin_i[j] ? sum + wj : sum - wj;
        end
        energy_o = current_spin_i ? sum : -sum;
    end

endmodule

// File: rtl/energy_calc_scheduler.sv
// Streams DATASPIN weight rows through one partial_energy_calc and accumulates the total energy.
// Ports: spin/weight/energy valid-ready pairs, config load, en_i abort, weight_idx_o address, busy_o.
module energy_calc_scheduler #(
    parameter int BITJ             = 4,
    parameter int BITH             = 4,
    parameter int DATASPIN         = 256,
    parameter int SCALING_BIT      = 5,
    parameter int LOCAL_ENERGY_BIT = 16,
    parameter int ENERGY_TOTAL_BIT = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        en_i,
    input  logic                        config_valid_i,
    input  logic [SCALING_BIT-1:0]      config_hscaling_i,
    input  logic                        spin_valid_i,
    output logic                        spin_ready_o,
    input  logic [DATASPIN-1:0]         spin_i,
    input  logic                        weight_valid_i,
    output logic                        weight_ready_o,
    input  logic [DATASPIN*BITJ-1:0]    weight_i,
    input  logic [BITH-1:0]             hbias_i,
    output logic [$clog2(DATASPIN)-1:0] weight_idx_o,
    output logic                        energy_valid_o,
    input  logic                        energy_ready_i,
    output logic [ENERGY_TOTAL_BIT-1:0] energy_o,
    output logic                        busy_o
);

    import energy_pkg::*;

    if (ENERGY_TOTAL_BIT < LOCAL_ENERGY_BIT + $clog2(DATASPIN)) begin : g_width_chk
        $error("ENERGY_TOTAL_BIT too narrow for worst-case sum");
    end
    if (DATASPIN != energy_pkg::DATASPIN ||
        LOCAL_ENERGY_BIT != LOCAL_W ||
        ENERGY_TOTAL_BIT != ENERGY_W) begin : g_pkg_chk
        $error("parameters disagree with energy_pkg");
    end

    localparam logic [IDX_W-1:0] LAST = IDX_W'(DATASPIN - 1);

    state_t                             state;
    logic [IDX_W-1:0]                   idx;
    logic [DATASPIN-1:0]                spin_reg;
    logic [SCALING_BIT-1:0]             hscale_reg;
    logic signed [LOCAL_ENERGY_BIT-1:0] part;
    logic signed [LOCAL_ENERGY_BIT-1:0] pipe_reg;
    logic                               pipe_vld;
    logic signed [ENERGY_TOTAL_BIT-1:0] acc;
    logic                               idle_q;
    logic                               spin_hs;
    logic                               weight_hs;

    // idle_q is 0 straight out of reset so every ready starts low.
    assign spin_ready_o = idle_q & en_i;
    assign spin_hs      = spin_valid_i & spin_ready_o;
    assign weight_hs    = weight_valid_i & weight_ready_o;
    assign weight_idx_o = idx;

    partial_energy_calc #(
        .BITJ             (BITJ),
        .BITH             (BITH),
        .DATASPIN         (DATASPIN),
        .SCALING_BIT      (SCALING_BIT),
        .LOCAL_ENERGY_BIT (LOCAL_ENERGY_BIT)
    ) u_pec (
        .spin_i         (spin_reg),
        .current_spin_i (spin_reg[idx]),
        .weight_i       (weight_i),
        .hbias_i        (hbias_i),
        .hscaling_i     (hscale_reg),
        .energy_o       (part)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= IDLE;
            idx            <= '0;
            spin_reg       <= '0;
            hscale_reg     <= '0;
            pipe_reg       <= '0;
            pipe_vld       <= 1'b0;
            acc            <= '0;
            energy_o       <= '0;
            idle_q         <= 1'b0;
            weight_ready_o <= 1'b0;
            energy_valid_o <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            pipe_vld <= 1'b0;
            if (pipe_vld) acc <= acc + sext_energy(pipe_reg);
            if (!en_i && state != IDLE) begin
                state          <= IDLE;
                idle_q         <= 1'b1;
                weight_ready_o <= 1'b0;
                energy_valid_o <= 1'b0;
                busy_o         <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        idle_q <= 1'b1;
                        if (config_valid_i && en_i) hscale_reg <= config_hscaling_i;
                        if (spin_hs) begin
                            spin_reg       <= spin_i;
                            acc            <= '0;
                            idx            <= '0;
                            state          <= FETCH;
                            idle_q         <= 1'b0;
                            weight_ready_o <= 1'b1;
                            busy_o         <= 1'b1;
                        end
                    end
                    FETCH: begin
                        if (weight_hs) begin
                            pipe_reg <= part;
                            pipe_vld <= 1'b1;
                            if (idx == LAST) begin
                                state          <= DRAIN;
                                weight_ready_o <= 1'b0;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    // Last row is still in pipe_reg; fold it in while publishing.
                    DRAIN: begin
                        energy_o       <= acc + sext_energy(pipe_reg);
                        state          <= DONE;
                        energy_valid_o <= 1'b1;
                    end
                    DONE: begin
                        if (energy_ready_i) begin
                            state          <= IDLE;
                            idle_q         <= 1'b1;
                            energy_valid_o <= 1'b0;
                            busy_o         <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_energy_calc_scheduler.sv
// Randomised and directed bench for energy_calc_scheduler against an arithmetic Ising model.
// Weight memory is modelled as arrays addressed by weight_idx_o.
module tb_energy_calc_scheduler;

    localparam int N = 256;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              en_i;
    logic              config_valid_i;
    logic [4:0]        config_hscaling_i;
    logic              spin_valid_i;
    logic              spin_ready_o;
    logic [N-1:0]      spin_i;
    logic              weight_valid_i;
    logic              weight_ready_o;
    logic [N*4-1:0]    weight_i;
    logic [3:0]        hbias_i;
    logic [7:0]        weight_idx_o;
    logic              energy_valid_o;
    logic              energy_ready_i;
    logic [31:0]       energy_o;
    logic              busy_o;

    logic [N*4-1:0]    wrow [N];
    logic [3:0]        hmem [N];
    int                cur_hs;
    int                compared = 0;
    int                mismatched = 0;

    always #5 clk = ~clk;

    assign weight_i = wrow[weight_idx_o];
    assign hbias_i  = hmem[weight_idx_o];

    energy_calc_scheduler dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .en_i              (en_i),
        .config_valid_i    (config_valid_i),
        .config_hscaling_i (config_hscaling_i),
        .spin_valid_i      (spin_valid_i),
        .spin_ready_o      (spin_ready_o),
        .spin_i            (spin_i),
        .weight_valid_i    (weight_valid_i),
        .weight_ready_o    (weight_ready_o),
        .weight_i          (weight_i),
        .hbias_i           (hbias_i),
        .weight_idx_o      (weight_idx_o),
        .energy_valid_o    (energy_valid_o),
        .energy_ready_i    (energy_ready_i),
        .energy_o          (energy_o),
        .busy_o            (busy_o)
    );

    // E = sum_i s_i * (sum_j J_ij s_j + h_i * hscaling), s = +/-1
    function automatic longint ref_energy(input logic [N-1:0] s, input int hs);
        longint e = 0;
        for (int i = 0; i < N; i++) begin
            longint loc = 0;
            for (int j = 0; j < N; j++) begin
                logic signed [3:0] w4 = wrow[i][j*4 +: 4];
                int w = w4;
                loc += s[j] ? w : -w;
            end
            begin
                logic signed [3:0] h4 = hmem[i];
                int h = h4;
                loc += h * hs;
            end
            e += s[i] ? loc : -loc;
        end
        return e;
    endfunction

    task automatic fill_const(input logic [3:0] w, input logic [3:0] h);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) wrow[i][j*4 +: 4] = w;
            hmem[i] = h;
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) wrow[i][j*4 +: 4] = 4'($urandom);
            hmem[i] = 4'($urandom);
        end
    endtask

    function automatic logic [N-1:0] rand_spins();
        logic [N-1:0] s;
        for (int k = 0; k < N / 32; k++) s[k*32 +: 32] = $urandom;
        return s;
    endfunction

    task automatic load_config(input int hs);
        @(negedge clk);
        config_valid_i    = 1'b1;
        config_hscaling_i = 5'(hs);
        @(negedge clk);
        config_valid_i    = 1'b0;
        cur_hs = hs;
    endtask

    // Runs one spin vector to completion; returns observations for the caller to check.
    task automatic do_run(
        input  logic [N-1:0] s,
        input  bit           stall,
        input  int           hold,
        input  bit           cfg_mid,
        output int           lat,
        output logic [31:0]  res,
        output int           idx_err,
        output int           last_idx,
        output int           hold_err,
        output bit           post_ok,
        output bit           timeout
    );
        int exp_idx = 0;
        idx_err  = 0;
        hold_err = 0;
        timeout  = 0;
        post_ok  = 0;
        last_idx = -1;
        res      = '0;
        @(negedge clk);
        spin_i         = s;
        spin_valid_i   = 1'b1;
        weight_valid_i = 1'b0;
        @(negedge clk);
        spin_valid_i = 1'b0;
        lat = 1;
        while (!energy_valid_o) begin
            if (lat > 3000) begin
                timeout = 1;
                break;
            end
            if (weight_ready_o) begin
                if (weight_idx_o !== 8'(exp_idx)) idx_err++;
                last_idx = int'(weight_idx_o);
            end
            config_valid_i = cfg_mid && (lat == 50);
            if (cfg_mid) config_hscaling_i = 5'd16;
            weight_valid_i = stall ? lat[0] : 1'b1;
            if (weight_ready_o && weight_valid_i && exp_idx < N - 1) exp_idx++;
            @(negedge clk);
            lat++;
        end
        config_valid_i = 1'b0;
        weight_valid_i = 1'b0;
        if (timeout) return;
        res = energy_o;
        for (int k = 0; k < hold; k++) begin
            energy_ready_i = 1'b0;
            @(negedge clk);
            if (energy_valid_o !== 1'b1 || busy_o !== 1'b1 || energy_o !== res) hold_err++;
        end
        energy_ready_i = 1'b1;
        @(negedge clk);
        energy_ready_i = 1'b0;
        post_ok = (energy_valid_o === 1'b0) && (busy_o === 1'b0);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        en_i = 1'b1;
        config_valid_i = 1'b0;
        config_hscaling_i = '0;
        spin_valid_i = 1'b0;
        spin_i = '0;
        weight_valid_i = 1'b0;
        energy_ready_i = 1'b0;
        #12;
        @(negedge clk);
        compared++;
        if ({spin_ready_o, weight_ready_o, energy_valid_o, busy_o} !== 4'b0 ||
            energy_o !== 32'd0 || weight_idx_o !== 8'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: got rdy/wrdy/vld/busy=%b energy=%0d idx=%0d want 0",
                     {spin_ready_o, weight_ready_o, energy_valid_o, busy_o},
                     energy_o, weight_idx_o);
        end
        rst_ni = 1'b1;
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (spin_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_ready: got spin_ready=%b busy=%b want 1/0", spin_ready_o, busy_o);
        end
    endtask

    task automatic test_zero();
        int lat, ie, li, he;
        logic [31:0] r;
        bit pok, to;
        fill_const(4'd0, 4'd0);
        load_config(1);
        do_run('0, 0, 0, 0, lat, r, ie, li, he, pok, to);
        compared++;
        if (to) begin
            mismatched++;
            $display("FAIL zero_timeout: no energy_valid_o within budget");
        end
        compared++;
        if (lat != N + 2) begin
            mismatched++;
            $display("FAIL zero_latency: got %0d want %0d", lat, N + 2);
        end
        compared++;
        if (r !== 32'd0) begin
            mismatched++;
            $display("FAIL zero_energy: got %0d want 0", $signed(r));
        end
        compared++;
        if (!pok || ie != 0) begin
            mismatched++;
            $display("FAIL zero_handshake: post_ok=%0d idx_err=%0d want 1/0", pok, ie);
        end
    endtask

    task automatic test_ones();
        int lat, ie, li, he;
        logic [31:0] r;
        bit pok, to;
        fill_const(4'b0111, 4'd0);
        do_run('1, 0, 0, 0, lat, r, ie, li, he, pok, to);
        compared++;
        if (to || r !== 32'(ref_energy('1, cur_hs)) || r !== 32'd458752) begin
            mismatched++;
            $display("FAIL ones_energy: got %0d want 458752 (timeout=%0d)", $signed(r), to);
        end
        compared++;
        if (li != N - 1) begin
            mismatched++;
            $display("FAIL ones_last_idx: got %0d want %0d", li, N - 1);
        end
    endtask

    task automatic test_stall();
        int lat, ie, li, he;
        logic [31:0] r;
        bit pok, to;
        do_run('1, 1, 0, 0, lat, r, ie, li, he, pok, to);
        compared++;
        if (to || r !== 32'd458752) begin
            mismatched++;
            $display("FAIL stall_energy: got %0d want 458752 (timeout=%0d)", $signed(r), to);
        end
        compared++;
        if (ie != 0 || li != N - 1) begin
            mismatched++;
            $display("FAIL stall_idx: got idx_err=%0d last=%0d want 0/%0d", ie, li, N - 1);
        end
        compared++;
        if (lat <= N + 2) begin
            mismatched++;
            $display("FAIL stall_latency: got %0d want > %0d", lat, N + 2);
        end
    endtask

    task automatic test_hold();
        int lat, ie, li, he;
        logic [31:0] r;
        bit pok, to;
        do_run('1, 1, 10, 0, lat, r, ie, li, he, pok, to);
        compared++;
        if (to || r !== 32'd458752) begin
            mismatched++;
            $display("FAIL hold_energy: got %0d want 458752 (timeout=%0d)", $signed(r), to);
        end
        compared++;
        if (he != 0) begin
            mismatched++;
            $display("FAIL hold_stable: got %0d unstable cycles want 0", he);
        end
        compared++;
        if (!pok) begin
            mismatched++;
            $display("FAIL hold_release: got valid=%b busy=%b want 0/0", energy_valid_o, busy_o);
        end
    endtask

    task automatic test_abort();
        int n = 0;
        int seen = 0;
        int lat, ie, li, he;
        logic [31:0] r;
        bit pok, to;
        @(negedge clk);
        spin_i = '1;
        spin_valid_i = 1'b1;
        @(negedge clk);
        spin_valid_i = 1'b0;
        weight_valid_i = 1'b1;
        while (weight_idx_o !== 8'd100 && n < 500) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (n >= 500) begin
            mismatched++;
            $display("FAIL abort_reach: idx %0d never reached 100", weight_idx_o);
        end
        en_i = 1'b0;
        @(negedge clk);
        weight_valid_i = 1'b0;
        compared++;
        if (busy_o !== 1'b0 || weight_ready_o !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_drop: got busy=%b wready=%b want 0/0", busy_o, weight_ready_o);
        end
        for (int k = 0; k < 300; k++) begin
            if (k == 5) en_i = 1'b1;
            if (energy_valid_o === 1'b1 || (k > 0 && busy_o === 1'b1)) seen++;
            @(negedge clk);
        end
        compared++;
        if (seen != 0) begin
            mismatched++;
            $display("FAIL abort_no_result: got %0d active cycles want 0", seen);
        end
        do_run('1, 0, 0, 0, lat, r, ie, li, he, pok, to);
        compared++;
        if (to || r !== 32'd458752) begin
            mismatched++;
            $display("FAIL abort_rerun: got %0d want 458752 (timeout=%0d)", $signed(r), to);
        end
    endtask

    task automatic test_enable_gate();
        en_i = 1'b0;
        spin_valid_i = 1'b1;
        spin_i = '1;
        #1;
        compared++;
        if (spin_ready_o !== 1'b0) begin
            mismatched++;
            $display("FAIL gate_ready: got %b want 0", spin_ready_o);
        end
        @(negedge clk);
        spin_valid_i = 1'b0;
        en_i = 1'b1;
        compared++;
        if (busy_o !== 1'b0) begin
            mismatched++;
            $display("FAIL gate_no_start: got busy=%b want 0", busy_o);
        end
    endtask

    task automatic test_config_ignore();
        int lat, ie, li, he;
        logic [31:0] r;
        logic [N-1:0] s;
        longint e;
        bit pok, to;
        fill_rand();
        load_config(1);
        s = rand_spins();
        e = ref_energy(s, 1);
        do_run(s, 0, 0, 1, lat, r, ie, li, he, pok, to);
        compared++;
        if (to || r !== 32'(e)) begin
            mismatched++;
            $display("FAIL config_ignored: got %0d want %0d", $signed(r), e);
        end
    endtask

    task automatic test_random();
        int lat, ie, li, he;
        logic [31:0] r;
        logic [N-1:0] s;
        longint e;
        bit pok, to;
        for (int t = 0; t < 3; t++) begin
            fill_rand();
            load_config($urandom_range(0, 31) - 16);
            s = rand_spins();
            e = ref_energy(s, cur_hs);
            do_run(s, t[0], t, 0, lat, r, ie, li, he, pok, to);
            compared++;
            if (to || r !== 32'(e) || ie != 0 || !pok) begin
                mismatched++;
                $display("FAIL random_%0d: got %0d want %0d hs=%0d idx_err=%0d post=%0d",
                         t, $signed(r), e, cur_hs, ie, pok);
            end
        end
    endtask

    initial begin
        cur_hs = 0;
        fill_const(4'd0, 4'd0);
        test_reset();
        test_zero();
        test_ones();
        test_stall();
        test_hold();
        test_abort();
        test_enable_gate();
        test_config_ignore();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/energy_calc_scheduler.md
Name: energy_calc_scheduler

Overview:
Sequences the combinational partial_energy_calc datapath over all DATASPIN rows to produce the total Ising energy of one spin configuration. It accepts a spin vector and streams in one weight row plus bias per cycle from the coupling memory. It drives a single shared partial_energy_calc instance and accumulates the per-row local energies. The result is returned through a valid/ready handshake to the annealing controller.

Parameters:
BITJ, 4, bit width of each signed coupling weight
BITH, 4, bit width of signed bias h
DATASPIN, 256, number of spins / weight rows
SCALING_BIT, 5, bit width of signed bias scaling factor
LOCAL_ENERGY_BIT, 16, width of partial energy from datapath
ENERGY_TOTAL_BIT, 32, accumulator/result width; must be >= LOCAL_ENERGY_BIT + $clog2(DATASPIN) (elaboration assertion)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
en_i  in  1  enable; low aborts any run
config_valid_i  in  1  load hscaling (accepted only in IDLE)
config_hscaling_i  in  SCALING_BIT  signed bias scaling factor
spin_valid_i  in  1  spin vector valid
spin_ready_o  out  1  spin vector accepted
spin_i  in  DATASPIN  spin configuration, bit=1 means +1
weight_valid_i  in  1  weight row valid
weight_ready_o  out  1  weight row accepted
weight_i  in  DATASPIN*BITJ  signed weight row for index weight_idx_o
hbias_i  in  BITH  signed bias for row weight_idx_o
weight_idx_o  out  $clog2(DATASPIN)  current row index (memory read address)
energy_valid_o  out  1  result valid
energy_ready_i  in  1  result consumed
energy_o  out  ENERGY_TOTAL_BIT  signed total energy
busy_o  out  1  high outside IDLE

Behaviour:
- Reset (async, rst_ni=0): FSM=IDLE; idx, accumulator, pipeline register, energy_o, hscaling register cleared; all valid/ready outputs 0; busy_o 0.
- IDLE: spin_ready_o = en_i. config_valid_i && en_i latches config_hscaling_i. On spin handshake, latch spin_i, clear accumulator, set idx=0, go to FETCH.
- FETCH:
  - weight_ready_o = 1. weight_idx_o = idx.
  - Datapath inputs: latched spins, current_spin = spin_reg[idx], weight_i, hbias_i, hscaling register.
  - On weight handshake: register the datapath output into pipe_reg with pipe_vld=1, then increment idx.
  - On the handshake with idx == DATASPIN-1, go to DRAIN; idx does not wrap.
  - weight_valid_i low: stall with no state change and pipe_vld=0 next cycle.
- Accumulator: every cycle pipe_vld=1, acc += sign-extended pipe_reg. No saturation; the width rule guarantees no overflow.
- DRAIN: one cycle for the last accumulation. Next cycle, energy_o = acc; go to DONE.
- DONE: energy_valid_o = 1. energy_o is held stable until energy_ready_i. On handshake, go to IDLE and drop energy_valid_o the next cycle.
- Latency: with no stalls, spin handshake at cycle 0 gives energy_valid_o high at cycle DATASPIN+2.
- en_i low in any non-IDLE state: next cycle FSM=IDLE; weight_ready_o and energy_valid_o drop to 0; the accumulator is discarded and no result is produced.
- config_valid_i outside IDLE: ignored. The latched hscaling stays constant for the whole run.
- spin_valid_i outside IDLE: not accepted (spin_ready_o=0).
- Same-cycle en_i low and spin_valid_i in IDLE: no handshake.

Decomposition:
- Shared package energy_pkg:
  - state enum {IDLE, FETCH, DRAIN, DONE}
  - localparam IDX_W = $clog2(DATASPIN)
  - function for sign-extending a partial energy to ENERGY_TOTAL_BIT
- One sub-module: partial_energy_calc, instantiated once as the shared datapath.
- Accumulator and pipeline register stay inline.

Test Plan:
- All spins 0, all weights 0, hbias 0, hscaling 1, no stalls -> energy_o = 0; energy_valid_o at cycle 258 after spin handshake.
- All spins 1, all weights +7 (4'b0111), hbias 0, hscaling 1 -> each partial 1792, energy_o = 458752.
- Same as previous with weight_valid_i toggled every other cycle -> energy_o = 458752; weight_idx_o increments only on handshakes; ends at 255.
- Same as previous with energy_ready_i held low 10 cycles after valid -> energy_o and energy_valid_o stable; busy_o high until the handshake, then IDLE.
- en_i dropped at idx=100 -> next cycle busy_o=0 and weight_ready_o=0; no energy_valid_o. A new run then gives the correct 458752.
- config_valid_i with hscaling=16 asserted during FETCH -> ignored; the result matches the golden model with the previously latched hscaling=1.
